trap_unit: RTL and testbench

Machine/supervisor trap sequencer that owns the architectural privilege level and the status fields defined by the core package's `mstatus`/`sstatus` layout. Sits directly downstream of the pipeline's exception/retire logic: it accepts one trap or return request at a time, updates status/epc/cause/tval state, and issues a PC redirect to the fetch stage. Provides the CSR read/write view of its own registers to the CSR file.

---
 rtl/trap_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_trap_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : trap_unit
// Brief    : M/S trap sequencer: privilege, status, epc/cause/tval, PC redirect.
//            Optional S-mode support enabled by defining TRAP_UNIT_SMODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module trap_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            trap_valid_i,
    output logic            trap_ready_o,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            sret_i,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_i,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [1:0]      priv_lvl_o,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAVE  = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam logic [1:0] c_priv_u    = 2'b00;
    localparam logic [1:0] c_priv_s    = 2'b01;
    localparam logic [1:0] c_priv_m    = 2'b11;
    localparam logic [1:0] c_kind_trap = 2'd0;
    localparam logic [1:0] c_kind_mret = 2'd1;
    localparam logic [1:0] c_kind_sret = 2'd2;
    localparam logic [XLEN-1:0] c_cause_illegal = XLEN'(2);

    state_t          r_state, w_state_nxt;
    logic            w_accept;
    logic [1:0]      r_kind;
    logic [XLEN-1:0] r_req_cause, r_req_pc, r_req_tval;
    logic [XLEN-1:0] r_target;

    logic [1:0]      r_priv;
    logic            r_mie, r_mpie;
    logic [1:0]      r_mpp;
    logic [XLEN-1:0] r_mtvec, r_mepc, r_mcause, r_mtval;
`ifdef TRAP_UNIT_SMODE_EN
    logic            r_sie, r_spie, r_spp;
    logic [XLEN-1:0] r_stvec, r_sepc, r_scause, r_stval, r_medeleg;
    logic            w_deleg;
`endif

    logic            w_mret_ok, w_sret_ok, w_mpp_legal, w_csr_we;
    logic [XLEN-1:0] w_mstatus;

    assign w_mret_ok = (r_priv == c_priv_m);
`ifdef TRAP_UNIT_SMODE_EN
    assign w_sret_ok   = (r_priv != c_priv_u);
    assign w_mpp_legal = (csr_wdata_i[12:11] != 2'b10);
    // Only synchronous exceptions from below M may be delegated.
    assign w_deleg     = (r_kind == c_kind_trap) && !r_req_cause[XLEN-1] &&
                         r_medeleg[r_req_cause[4:0]] && (r_priv != c_priv_m);
`else
    assign w_sret_ok   = 1'b0;
    assign w_mpp_legal = (csr_wdata_i[12:11] == c_priv_m) ||
                         (csr_wdata_i[12:11] == c_priv_u);
`endif
    assign w_csr_we = csr_we_i && (r_state == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (trap_valid_i || mret_i || sret_i) begin
                    w_state_nxt = SAVE;
                    w_accept    = 1'b1;
                end
            end
            SAVE:    w_state_nxt = REDIR;
            REDIR:   if (redirect_ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture; an illegal return is turned into an illegal-instruction trap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_kind      <= c_kind_trap;
            r_req_cause <= '0;
            r_req_pc    <= '0;
            r_req_tval  <= '0;
        end else if (w_accept) begin
            r_req_pc <= trap_pc_i;
            if (trap_valid_i) begin
                r_kind      <= c_kind_trap;
                r_req_cause <= trap_cause_i;
                r_req_tval  <= trap_tval_i;
            end else if (mret_i && w_mret_ok) begin
                r_kind <= c_kind_mret;
            end else if (!mret_i && w_sret_ok) begin
                r_kind <= c_kind_sret;
            end else begin
                r_kind      <= c_kind_trap;
                r_req_cause <= c_cause_illegal;
                r_req_tval  <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_priv   <= c_priv_m;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mpp    <= c_priv_m;
            r_mtvec  <= MTVEC_RESET;
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
            r_target <= '0;
`ifdef TRAP_UNIT_SMODE_EN
            r_sie     <= 1'b0;
            r_spie    <= 1'b0;
            r_spp     <= 1'b0;
            r_stvec   <= '0;
            r_sepc    <= '0;
            r_scause  <= '0;
            r_stval   <= '0;
            r_medeleg <= '0;
`endif
        end else if (r_state == SAVE) begin
            case (r_kind)
                c_kind_mret: begin
                    r_priv   <= r_mpp;
                    r_mie    <= r_mpie;
                    r_mpie   <= 1'b1;
                    r_mpp    <= c_priv_u;
                    r_target <= r_mepc;
                end
`ifdef TRAP_UNIT_SMODE_EN
                c_kind_sret: begin
                    r_priv   <= r_spp ? c_priv_s : c_priv_u;
                    r_sie    <= r_spie;
                    r_spie   <= 1'b1;
                    r_spp    <= 1'b0;
                    r_target <= r_sepc;
                end
`endif
                default: begin
`ifdef TRAP_UNIT_SMODE_EN
                    if (w_deleg) begin
                        r_sepc   <= {r_req_pc[XLEN-1:2], 2'b00};
                        r_scause <= r_req_cause;
                        r_stval  <= r_req_tval;
                        r_spie   <= r_sie;
                        r_sie    <= 1'b0;
                        r_spp    <= r_priv[0];
                        r_priv   <= c_priv_s;
                        r_target <= r_stvec;
                    end else
`endif
                    begin
                        r_mepc   <= {r_req_pc[XLEN-1:2], 2'b00};
                        r_mcause <= r_req_cause;
                        r_mtval  <= r_req_tval;
                        r_mpie   <= r_mie;
                        r_mie    <= 1'b0;
                        r_mpp    <= r_priv;
                        r_priv   <= c_priv_m;
                        r_target <= {r_mtvec[XLEN-1:2], 2'b00};
                    end
                end
            endcase
        end else if (w_csr_we) begin
            case (csr_addr_i)
                12'h300: begin
                    r_mie  <= csr_wdata_i[3];
                    r_mpie <= csr_wdata_i[7];
                    if (w_mpp_legal) r_mpp <= csr_wdata_i[12:11];
`ifdef TRAP_UNIT_SMODE_EN
                    r_sie  <= csr_wdata_i[1];
                    r_spie <= csr_wdata_i[5];
                    r_spp  <= csr_wdata_i[8];
`endif
                end
                12'h305: r_mtvec  <= {csr_wdata_i[XLEN-1:2], 2'b00};
                12'h341: r_mepc   <= {csr_wdata_i[XLEN-1:2], 2'b00};
                12'h342: r_mcause <= csr_wdata_i;
                12'h343: r_mtval  <= csr_wdata_i;
`ifdef TRAP_UNIT_SMODE_EN
                12'h100: begin
                    r_sie  <= csr_wdata_i[1];
                    r_spie <= csr_wdata_i[5];
                    r_spp  <= csr_wdata_i[8];
                end
                12'h105: r_stvec   <= {csr_wdata_i[XLEN-1:2], 2'b00};
                12'h141: r_sepc    <= {csr_wdata_i[XLEN-1:2], 2'b00};
                12'h142: r_scause  <= csr_wdata_i;
                12'h143: r_stval   <= csr_wdata_i;
                12'h302: r_medeleg <= csr_wdata_i;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        w_mstatus        = '0;
        w_mstatus[3]     = r_mie;
        w_mstatus[7]     = r_mpie;
        w_mstatus[12:11] = r_mpp;
`ifdef TRAP_UNIT_SMODE_EN
        w_mstatus[1]     = r_sie;
        w_mstatus[5]     = r_spie;
        w_mstatus[8]     = r_spp;
`endif
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            12'h300: csr_rdata_o = w_mstatus;
            12'h305: csr_rdata_o = r_mtvec;
            12'h341: csr_rdata_o = r_mepc;
            12'h342: csr_rdata_o = r_mcause;
            12'h343: csr_rdata_o = r_mtval;
`ifdef TRAP_UNIT_SMODE_EN
            12'h100: begin
                csr_rdata_o[1] = r_sie;
                csr_rdata_o[5] = r_spie;
                csr_rdata_o[8] = r_spp;
            end
            12'h105: csr_rdata_o = r_stvec;
            12'h141: csr_rdata_o = r_sepc;
            12'h142: csr_rdata_o = r_scause;
            12'h143: csr_rdata_o = r_stval;
            12'h302: csr_rdata_o = r_medeleg;
`endif
            default: csr_rdata_o = '0;
        endcase
    end

    assign trap_ready_o     = (r_state == IDLE);
    assign redirect_valid_o = (r_state == REDIR);
    assign redirect_pc_o    = r_target;
    assign priv_lvl_o       = r_priv;

endmodule
`default_nettype wire

// File: tb/tb_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_unit
// Brief    : Randomized scoreboard bench for trap_unit against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid_i, trap_ready_o, mret_i, sret_i;
    logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
    logic        redirect_valid_o, redirect_ready_i;
    logic [31:0] redirect_pc_o;
    logic [1:0]  priv_lvl_o;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i, csr_rdata_o;

    trap_unit #(.XLEN(32), .MTVEC_RESET(32'h0000_0100)) dut (
        .clk_i(clk), .rst_i(rst),
        .trap_valid_i(trap_valid_i), .trap_ready_o(trap_ready_o),
        .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i),
        .mret_i(mret_i), .sret_i(sret_i),
        .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
        .redirect_pc_o(redirect_pc_o), .priv_lvl_o(priv_lvl_o),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  priv;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: architectural state as plain variables
    logic [1:0]  m_priv, m_mpp;
    logic        m_mie, m_mpie, m_sie, m_spie, m_spp;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
    logic [31:0] m_stvec, m_sepc, m_scause, m_stval, m_medeleg;
`ifdef TRAP_UNIT_SMODE_EN
    localparam bit SMODE = 1'b1;
`else
    localparam bit SMODE = 1'b0;
`endif

    task automatic m_reset();
        m_priv = 2'b11; m_mie = 0; m_mpie = 0; m_mpp = 2'b11;
        m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_sie = 0; m_spie = 0; m_spp = 0;
        m_stvec = 0; m_sepc = 0; m_scause = 0; m_stval = 0; m_medeleg = 0;
    endtask

    function automatic logic [31:0] m_mstatus();
        logic [31:0] v = (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
        if (SMODE) v = v | (32'(m_spp) << 8) | (32'(m_spie) << 5) | (32'(m_sie) << 1);
        return v;
    endfunction

    function automatic logic [31:0] m_csr(logic [11:0] a);
        case (a)
            12'h300: return m_mstatus();
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: ;
        endcase
        if (SMODE) begin
            case (a)
                12'h100: return (32'(m_spp) << 8) | (32'(m_spie) << 5) | (32'(m_sie) << 1);
                12'h105: return m_stvec;
                12'h141: return m_sepc;
                12'h142: return m_scause;
                12'h143: return m_stval;
                12'h302: return m_medeleg;
                default: ;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic m_write(logic [11:0] a, logic [31:0] d);
        case (a)
            12'h300: begin
                m_mie = d[3]; m_mpie = d[7];
                if (d[12:11] == 2'b11 || d[12:11] == 2'b00 || (SMODE && d[12:11] == 2'b01))
                    m_mpp = d[12:11];
                if (SMODE) begin m_sie = d[1]; m_spie = d[5]; m_spp = d[8]; end
            end
            12'h305: m_mtvec  = d & ~32'h3;
            12'h341: m_mepc   = d & ~32'h3;
            12'h342: m_mcause = d;
            12'h343: m_mtval  = d;
            default: ;
        endcase
        if (SMODE) begin
            case (a)
                12'h100: begin m_sie = d[1]; m_spie = d[5]; m_spp = d[8]; end
                12'h105: m_stvec   = d & ~32'h3;
                12'h141: m_sepc    = d & ~32'h3;
                12'h142: m_scause  = d;
                12'h143: m_stval   = d;
                12'h302: m_medeleg = d;
                default: ;
            endcase
        end
    endtask

    task automatic m_trap(logic [31:0] cause, logic [31:0] pc, logic [31:0] tval,
                          output logic [31:0] tgt);
        if (SMODE && !cause[31] && m_medeleg[cause[4:0]] && m_priv != 2'b11) begin
            m_sepc = pc & ~32'h3; m_scause = cause; m_stval = tval;
            m_spie = m_sie; m_sie = 0; m_spp = m_priv[0]; m_priv = 2'b01;
            tgt = m_stvec;
        end else begin
            m_mepc = pc & ~32'h3; m_mcause = cause; m_mtval = tval;
            m_mpie = m_mie; m_mie = 0; m_mpp = m_priv; m_priv = 2'b11;
            tgt = m_mtvec;
        end
    endtask

    task automatic m_req(bit t, bit m, bit s, logic [31:0] cause, logic [31:0] pc,
                         logic [31:0] tval, output logic [31:0] tgt);
        if (t) m_trap(cause, pc, tval, tgt);
        else if (m) begin
            if (m_priv != 2'b11) m_trap(32'd2, pc, 32'd0, tgt);
            else begin
                tgt = m_mepc; m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 2'b00;
            end
        end else begin
            if (!SMODE || m_priv == 2'b00) m_trap(32'd2, pc, 32'd0, tgt);
            else begin
                tgt = m_sepc; m_priv = m_spp ? 2'b01 : 2'b00;
                m_sie = m_spie; m_spie = 1; m_spp = 0;
            end
        end
    endtask

    // Monitor: compare each new redirect against the oldest expectation
    logic prev_v = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (redirect_valid_o && !prev_v) begin
            if (sb.size() == 0) chk("sb_unexpected_redirect", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                chk("redirect_pc", redirect_pc_o, mon_e.pc);
                chk("redirect_priv", 32'(priv_lvl_o), 32'(mon_e.priv));
                chk("redirect_latency", cyc, mon_e.cyc);
            end
        end
        prev_v = redirect_valid_o;
    end

    task automatic csr_wr(logic [11:0] a, logic [31:0] d);
        @(negedge clk);
        csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
        @(posedge clk); #1;
        csr_we_i = 0;
        m_write(a, d);
    endtask

    task automatic rd_chk(string name, logic [11:0] a);
        @(negedge clk);
        csr_addr_i = a; #1;
        chk(name, csr_rdata_o, m_csr(a));
    endtask

    task automatic rd_lit(string name, logic [11:0] a, logic [31:0] lit);
        @(negedge clk);
        csr_addr_i = a; #1;
        chk(name, csr_rdata_o, lit);
    endtask

    task automatic issue(bit t, bit m, bit s, logic [31:0] cause, logic [31:0] pc,
                         logic [31:0] tval, int stall);
        logic [31:0] tgt;
        exp_t e;
        int n;
        @(negedge clk);
        chk("trap_ready_idle", 32'(trap_ready_o), 32'd1);
        trap_valid_i = t; mret_i = m; sret_i = s;
        trap_cause_i = cause; trap_pc_i = pc; trap_tval_i = tval;
        m_req(t, m, s, cause, pc, tval, tgt);
        e.pc = tgt; e.priv = m_priv; e.cyc = cyc + 2;
        sb.push_back(e);
        @(posedge clk); #1;
        trap_valid_i = 0; mret_i = 0; sret_i = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!redirect_valid_o && n < 10);
        if (!redirect_valid_o) begin
            chk("redirect_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(redirect_valid_o), 32'd1);
            chk("stall_pc", redirect_pc_o, tgt);
            chk("stall_ready", 32'(trap_ready_o), 32'd0);
            csr_we_i = 1; csr_addr_i = 12'h305; csr_wdata_i = $urandom;
            @(negedge clk);
        end
        csr_we_i = 0;
        redirect_ready_i = 1;
        @(posedge clk); #1;
        redirect_ready_i = 0;
    endtask

    task automatic check_state();
        rd_chk("mstatus", 12'h300);
        rd_chk("mepc", 12'h341);
        rd_chk("mcause", 12'h342);
        rd_chk("mtvec", 12'h305);
        chk("priv", 32'(priv_lvl_o), 32'(m_priv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; trap_valid_i = 0; mret_i = 0; sret_i = 0;
        trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0;
        redirect_ready_i = 0; csr_we_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(trap_ready_o), 32'd1);
        chk("rst_valid", 32'(redirect_valid_o), 32'd0);
        chk("rst_pc", redirect_pc_o, 32'd0);
        chk("rst_priv", 32'(priv_lvl_o), 32'd3);
        rd_lit("rst_mstatus", 12'h300, 32'h0000_1800);
        rd_lit("rst_mtvec", 12'h305, 32'h0000_0100);
        rd_lit("unowned_csr", 12'h7C0, 32'h0);

        // Trap cause 11 from M
        issue(1, 0, 0, 32'd11, 32'h8000_0042, 32'h1234, 0);
        rd_lit("t1_mepc", 12'h341, 32'h8000_0040);
        rd_lit("t1_mcause", 12'h342, 32'd11);
        rd_lit("t1_mstatus", 12'h300, 32'h0000_1800);

        // mret to U
        csr_wr(12'h300, 32'h0000_0080);
        issue(0, 1, 0, 32'd0, 32'h0, 32'h0, 0);
        chk("t2_priv_u", 32'(priv_lvl_o), 32'd0);
        rd_lit("t2_mstatus", 12'h300, 32'h0000_0088);

        // Illegal mret in U, then simultaneous trap+mret
        issue(0, 1, 0, 32'd0, 32'h0000_4006, 32'h0, 0);
        rd_lit("t3_mcause", 12'h342, 32'd2);
        rd_lit("t3_mstatus", 12'h300, 32'h0000_0080);
        issue(1, 1, 0, 32'd5, 32'h0000_5000, 32'h77, 0);
        rd_lit("t3_both_mcause", 12'h342, 32'd5);

        // Stalled redirect with ignored CSR writes
        issue(1, 0, 0, 32'd3, 32'h0000_6000, 32'h0, 5);
        rd_lit("t4_mtvec", 12'h305, 32'h0000_0100);
        check_state();

`ifdef TRAP_UNIT_SMODE_EN
        csr_wr(12'h302, 32'h0000_0100);
        csr_wr(12'h105, 32'h0000_2000);
        csr_wr(12'h300, 32'h0000_0000);
        issue(0, 1, 0, 32'd0, 32'h0, 32'h0, 0);
        issue(1, 0, 0, 32'd8, 32'h0000_7000, 32'h0, 0);
        chk("s_priv_s", 32'(priv_lvl_o), 32'd1);
        rd_lit("s_sepc", 12'h141, 32'h0000_7000);
        rd_lit("s_sstatus_spp0", 12'h100, 32'h0);
        issue(0, 0, 1, 32'd0, 32'h0, 32'h0, 0);
        chk("s_sret_priv_u", 32'(priv_lvl_o), 32'd0);
        issue(1, 0, 0, 32'h8000_0007, 32'h0000_7100, 32'h0, 0);
        chk("s_irq_priv_m", 32'(priv_lvl_o), 32'd3);
`else
        issue(0, 0, 1, 32'd0, 32'h0000_7200, 32'h0, 0);
        rd_lit("sret_illegal_cause", 12'h342, 32'd2);
        rd_lit("s_csr_absent", 12'h105, 32'h0);
`endif

        // Randomized operations
        for (int k = 0; k < 60; k++) begin
            int op;
            logic [31:0] c;
            op = $urandom_range(0, 6);
            c  = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 11)))
                                              : 32'($urandom_range(0, 15));
            case (op)
                0, 1: issue(1, 0, 0, c, $urandom, $urandom, $urandom_range(0, 2));
                2:    issue(0, 1, 0, 0, $urandom, 0, $urandom_range(0, 2));
                3:    issue(0, 0, 1, 0, $urandom, 0, $urandom_range(0, 2));
                4:    issue(1, 1, 1, c, $urandom, $urandom, 0);
                5:    csr_wr(12'h300, $urandom);
                default: begin
                    case ($urandom_range(0, 4))
                        0: csr_wr(12'h305, $urandom);
                        1: csr_wr(12'h341, $urandom);
                        2: csr_wr(12'h302, $urandom);
                        3: csr_wr(12'h105, $urandom);
                        default: csr_wr(12'h141, $urandom);
                    endcase
                end
            endcase
            check_state();
            rd_chk("rand_sstatus", 12'h100);
            rd_chk("rand_sepc", 12'h141);
        end

        // Reset while redirect pending
        csr_wr(12'h305, 32'h0000_9000);
        begin
            exp_t e;
            logic [31:0] tgt;
            int n;
            @(negedge clk);
            trap_valid_i = 1; mret_i = 0; sret_i = 0;
            trap_cause_i = 32'd4; trap_pc_i = 32'h0000_A000; trap_tval_i = 0;
            m_req(1, 0, 0, 32'd4, 32'h0000_A000, 32'd0, tgt);
            e.pc = tgt; e.priv = m_priv; e.cyc = cyc + 2;
            sb.push_back(e);
            @(posedge clk); #1;
            trap_valid_i = 0;
            n = 0;
            do begin @(negedge clk); n++; end while (!redirect_valid_o && n < 10);
            chk("rr_valid_before", 32'(redirect_valid_o), 32'd1);
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
            m_reset();
            @(negedge clk);
            chk("rr_valid_dropped", 32'(redirect_valid_o), 32'd0);
            chk("rr_priv", 32'(priv_lvl_o), 32'd3);
            chk("rr_ready", 32'(trap_ready_o), 32'd1);
            rd_lit("rr_mtvec", 12'h305, 32'h0000_0100);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
